// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Client-side and uart_tx-side handshake bundle of the arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   cli_tx_start;
  logic [8*NUM_REQ-1:0] cli_tx_data;
  logic [NUM_REQ-1:0]   cli_tx_busy;
  logic                 uart_tx_start;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_busy;

  // Arbiter side
  modport slave (
    input  req, cli_tx_start, cli_tx_data, uart_tx_busy,
    output gnt, cli_tx_busy, uart_tx_start, uart_tx_data
  );

  // Clients plus uart_tx side
  modport master (
    output req, cli_tx_start, cli_tx_data, uart_tx_busy,
    input  gnt, cli_tx_busy, uart_tx_start, uart_tx_data
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Message-level round-robin arbiter sharing one uart_tx, with
//               an owner-stall watchdog.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TMO_W       = 26
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_arbiter_if.slave bus,
  output logic [ID_W-1:0] active_id,
  output logic            arb_busy,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     active_id_q, active_id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  lockout_q, lockout_d;
  logic                start_pend_q, start_pend_d;
  logic                uart_tx_start_q, uart_tx_start_d;
  logic [7:0]          uart_tx_data_q, uart_tx_data_d;
  logic                timeout_err_q, timeout_err_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;

  logic                owner_req;
  logic                owner_start;
  logic [7:0]          owner_byte;
  logic                owner_busy;
  logic                fwd;
  logic [NUM_REQ-1:0]  eligible;
  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  int                  best_dist;

  // Owner view muxed by loop so no index ever leaves 0..NUM_REQ-1
  always_comb begin
    owner_req   = 1'b0;
    owner_start = 1'b0;
    owner_byte  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (active_id_q == ID_W'(i)) begin
        owner_req   = bus.req[i];
        owner_start = bus.cli_tx_start[i];
        owner_byte  = bus.cli_tx_data[8*i +: 8];
      end
    end
  end

  // start_pend bridges the gap between our strobe and uart_tx raising busy
  assign owner_busy = bus.uart_tx_busy | start_pend_q | uart_tx_start_q;
  assign fwd        = (state_q == GRANT) && owner_start && !owner_busy;
  assign eligible   = bus.req & ~lockout_q;

  // Round-robin pick: smallest distance after rr_ptr wins
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    best_dist  = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (eligible[i] &&
          (((i + 2*NUM_REQ - 1 - int'(rr_ptr_q)) % NUM_REQ) < best_dist)) begin
        best_dist  = (i + 2*NUM_REQ - 1 - int'(rr_ptr_q)) % NUM_REQ;
        pick_found = 1'b1;
        pick_idx   = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    active_id_d     = active_id_q;
    rr_ptr_d        = rr_ptr_q;
    lockout_d       = lockout_q & bus.req;
    start_pend_d    = start_pend_q;
    uart_tx_start_d = 1'b0;
    uart_tx_data_d  = uart_tx_data_q;
    timeout_err_d   = 1'b0;
    tmo_cnt_d       = tmo_cnt_q;

    if (fwd) begin
      uart_tx_start_d = 1'b1;
      uart_tx_data_d  = owner_byte;
      start_pend_d    = 1'b1;
    end else if (bus.uart_tx_busy) begin
      start_pend_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pick_found && !bus.uart_tx_busy) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            gnt_d[i] = (pick_idx == ID_W'(i));
          end
          active_id_d = pick_idx;
          tmo_cnt_d   = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (fwd) begin
          tmo_cnt_d = '0;
        end else if (!owner_busy && !owner_start) begin
          if ((TIMEOUT_CYC != 0) && (tmo_cnt_q == TMO_LAST)) begin
            timeout_err_d = 1'b1;
            lockout_d     = lockout_d | (gnt_q & bus.req);
            state_d       = DRAIN;
          end else if (tmo_cnt_q != '1) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
        if (!owner_req) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.uart_tx_busy && !start_pend_q && !uart_tx_start_q) begin
          gnt_d    = '0;
          rr_ptr_d = active_id_q;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      gnt_q           <= '0;
      active_id_q     <= '0;
      rr_ptr_q        <= ID_W'(NUM_REQ - 1);
      lockout_q       <= '0;
      start_pend_q    <= 1'b0;
      uart_tx_start_q <= 1'b0;
      uart_tx_data_q  <= 8'h00;
      timeout_err_q   <= 1'b0;
      tmo_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      active_id_q     <= active_id_d;
      rr_ptr_q        <= rr_ptr_d;
      lockout_q       <= lockout_d;
      start_pend_q    <= start_pend_d;
      uart_tx_start_q <= uart_tx_start_d;
      uart_tx_data_q  <= uart_tx_data_d;
      timeout_err_q   <= timeout_err_d;
      tmo_cnt_q       <= tmo_cnt_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cli_busy
      assign bus.cli_tx_busy[gi] = !((state_q == GRANT) && gnt_q[gi]) || owner_busy;
    end
  endgenerate

  assign bus.gnt           = gnt_q;
  assign bus.uart_tx_start = uart_tx_start_q;
  assign bus.uart_tx_data  = uart_tx_data_q;
  assign active_id         = active_id_q;
  assign arb_busy          = (state_q != IDLE);
  assign timeout_err       = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] active_id;
  logic       arb_busy;
  logic       timeout_err;
  int         checks = 0;
  int         errors = 0;

  uart_tx_arbiter_if #(.NUM_REQ(3)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ    (3),
    .ID_W       (2),
    .TIMEOUT_CYC(16),
    .TMO_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .active_id  (active_id),
    .arb_busy   (arb_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout sim_time=%0t limit=200000", $time);
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 3'b000; bus.cli_tx_start = 3'b000; bus.cli_tx_data = 24'h0; bus.uart_tx_busy = 1'b0;
    step(); step();
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt got=%b exp=000", bus.gnt); end
    checks++; if (bus.uart_tx_start !== 1'b0) begin errors++; $display("FAIL rst_start got=%b exp=0", bus.uart_tx_start); end
    checks++; if (bus.uart_tx_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", bus.uart_tx_data); end
    checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL rst_id got=%0d exp=0", active_id); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_tmo got=%b exp=0", timeout_err); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL rst_arb_busy got=%b exp=0", arb_busy); end
    checks++; if (bus.cli_tx_busy !== 3'b111) begin errors++; $display("FAIL rst_cli_busy got=%b exp=111", bus.cli_tx_busy); end
    rst = 1'b0;
    step();
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL idle_gnt got=%b exp=000", bus.gnt); end
  endtask

  task automatic test_grant();
    bus.req = 3'b011;
    step();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL grant_first got=%b exp=001", bus.gnt); end
    checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL grant_id got=%0d exp=0", active_id); end
    checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL grant_arb_busy got=%b exp=1", arb_busy); end
    checks++; if (bus.cli_tx_busy !== 3'b110) begin errors++; $display("FAIL grant_cli_busy got=%b exp=110", bus.cli_tx_busy); end
    bus.req = 3'b010;
    step();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL drain_hold got=%b exp=001", bus.gnt); end
    step();
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL drain_release got=%b exp=000", bus.gnt); end
    step();
    checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL grant_second got=%b exp=010", bus.gnt); end
    checks++; if (active_id !== 2'd1) begin errors++; $display("FAIL grant_second_id got=%0d exp=1", active_id); end
    bus.req = 3'b000;
    step(); step();
  endtask

  task automatic test_send();
    bus.req = 3'b001;
    step();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL send_gnt got=%b exp=001", bus.gnt); end
    bus.cli_tx_start = 3'b001; bus.cli_tx_data = 24'h000031;
    step();
    bus.cli_tx_start = 3'b000;
    checks++; if (bus.uart_tx_start !== 1'b1) begin errors++; $display("FAIL send_start got=%b exp=1", bus.uart_tx_start); end
    checks++; if (bus.uart_tx_data !== 8'h31) begin errors++; $display("FAIL send_data got=%h exp=31", bus.uart_tx_data); end
    checks++; if (bus.cli_tx_busy[0] !== 1'b1) begin errors++; $display("FAIL send_busy_start got=%b exp=1", bus.cli_tx_busy[0]); end
    bus.uart_tx_busy = 1'b1;
    step();
    checks++; if (bus.uart_tx_start !== 1'b0) begin errors++; $display("FAIL send_pulse_len got=%b exp=0", bus.uart_tx_start); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.cli_tx_busy[0] !== 1'b1) begin errors++; $display("FAIL send_busy_hold k=%0d got=%b exp=1", k, bus.cli_tx_busy[0]); end
    end
    bus.uart_tx_busy = 1'b0;
    #1;
    checks++; if (bus.cli_tx_busy[0] !== 1'b0) begin errors++; $display("FAIL send_busy_release got=%b exp=0", bus.cli_tx_busy[0]); end
    step();
    // uart_tx slow to raise busy: start_pend must cover the gap
    bus.cli_tx_start = 3'b001; bus.cli_tx_data = 24'h000032;
    step();
    bus.cli_tx_start = 3'b000;
    checks++; if (bus.uart_tx_data !== 8'h32) begin errors++; $display("FAIL send2_data got=%h exp=32", bus.uart_tx_data); end
    step();
    checks++; if (bus.cli_tx_busy[0] !== 1'b1) begin errors++; $display("FAIL send2_pend_gap got=%b exp=1", bus.cli_tx_busy[0]); end
    bus.uart_tx_busy = 1'b1;
    step();
    checks++; if (bus.cli_tx_busy[0] !== 1'b1) begin errors++; $display("FAIL send2_busy got=%b exp=1", bus.cli_tx_busy[0]); end
    bus.uart_tx_busy = 1'b0;
    #1;
    checks++; if (bus.cli_tx_busy[0] !== 1'b0) begin errors++; $display("FAIL send2_release got=%b exp=0", bus.cli_tx_busy[0]); end
    step();
  endtask

  task automatic test_nonowner();
    bus.req = 3'b011; bus.cli_tx_start = 3'b010; bus.cli_tx_data = 24'h004100;
    step();
    checks++; if (bus.uart_tx_start !== 1'b0) begin errors++; $display("FAIL nonowner_start got=%b exp=0", bus.uart_tx_start); end
    checks++; if (bus.cli_tx_busy[1] !== 1'b1) begin errors++; $display("FAIL nonowner_busy got=%b exp=1", bus.cli_tx_busy[1]); end
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL nonowner_gnt got=%b exp=001", bus.gnt); end
    step();
    checks++; if (bus.uart_tx_start !== 1'b0) begin errors++; $display("FAIL nonowner_start2 got=%b exp=0", bus.uart_tx_start); end
    bus.cli_tx_start = 3'b000;
    bus.uart_tx_busy = 1'b1; bus.cli_tx_start = 3'b001; bus.cli_tx_data = 24'h0000AA;
    step();
    bus.cli_tx_start = 3'b000;
    checks++; if (bus.uart_tx_start !== 1'b0) begin errors++; $display("FAIL busy_strobe_start got=%b exp=0", bus.uart_tx_start); end
    step();
    checks++; if (bus.uart_tx_data !== 8'h32) begin errors++; $display("FAIL busy_strobe_data got=%h exp=32", bus.uart_tx_data); end
    bus.uart_tx_busy = 1'b0;
    step();
  endtask

  task automatic test_drain();
    bus.cli_tx_start = 3'b001; bus.cli_tx_data = 24'h000055; bus.req = 3'b010;
    step();
    bus.cli_tx_start = 3'b000;
    checks++; if (bus.uart_tx_start !== 1'b1) begin errors++; $display("FAIL drop_strobe_start got=%b exp=1", bus.uart_tx_start); end
    checks++; if (bus.uart_tx_data !== 8'h55) begin errors++; $display("FAIL drop_strobe_data got=%h exp=55", bus.uart_tx_data); end
    bus.uart_tx_busy = 1'b1;
    step();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL drain_mid1 got=%b exp=001", bus.gnt); end
    checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL drain_arb_busy got=%b exp=1", arb_busy); end
    step();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL drain_mid2 got=%b exp=001", bus.gnt); end
    bus.uart_tx_busy = 1'b0;
    step();
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL drain_end got=%b exp=000", bus.gnt); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL drain_idle got=%b exp=0", arb_busy); end
    step();
    checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL drain_next got=%b exp=010", bus.gnt); end
    checks++; if (active_id !== 2'd1) begin errors++; $display("FAIL drain_next_id got=%0d exp=1", active_id); end
    bus.req = 3'b000;
    step(); step();
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL drain_done got=%b exp=000", bus.gnt); end
  endtask

  task automatic test_timeout();
    bus.req = 3'b001;
    step();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL tmo_gnt got=%b exp=001", bus.gnt); end
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (timeout_err !== (k == 16)) begin errors++; $display("FAIL tmo_pulse k=%0d got=%b exp=%b", k, timeout_err, (k == 16)); end
    end
    step();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_one_cycle got=%b exp=0", timeout_err); end
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL tmo_release got=%b exp=000", bus.gnt); end
    step(); step(); step();
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL tmo_lockout got=%b exp=000", bus.gnt); end
    bus.req = 3'b000;
    step();
    bus.req = 3'b001;
    step();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL tmo_reeligible got=%b exp=001", bus.gnt); end
    bus.req = 3'b000;
    step(); step();
  endtask

  task automatic test_rst_mid();
    bus.req = 3'b011;
    step();
    checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL rr_after_0 got=%b exp=010", bus.gnt); end
    bus.cli_tx_start = 3'b010; bus.cli_tx_data = 24'h007700;
    step();
    bus.cli_tx_start = 3'b000;
    checks++; if (bus.uart_tx_data !== 8'h77) begin errors++; $display("FAIL rst_mid_data got=%h exp=77", bus.uart_tx_data); end
    rst = 1'b1;
    #1;
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL rst_mid_gnt got=%b exp=000", bus.gnt); end
    checks++; if (bus.uart_tx_start !== 1'b0) begin errors++; $display("FAIL rst_mid_start got=%b exp=0", bus.uart_tx_start); end
    checks++; if (bus.uart_tx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data0 got=%h exp=00", bus.uart_tx_data); end
    checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL rst_mid_id got=%0d exp=0", active_id); end
    checks++; if (bus.cli_tx_busy !== 3'b111) begin errors++; $display("FAIL rst_mid_cli_busy got=%b exp=111", bus.cli_tx_busy); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_arb_busy got=%b exp=0", arb_busy); end
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL rst_mid_fresh got=%b exp=001", bus.gnt); end
    checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL rst_mid_fresh_id got=%0d exp=0", active_id); end
    bus.req = 3'b000;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_grant();
    test_send();
    test_nonowner();
    test_drain();
    test_timeout();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
